vga_sync: RTL and testbench
===========================

Name: vga_sync

Overview:
- Generates 640x480@60 Hz VGA timing and drives the pixel coordinate bus (x_crd, y_crd) consumed by the game renderer.
- Takes back the renderer's combinational colour bits, registers them, blanks them outside the active area, and drives them to the connector pins aligned with hsync/vsync.
- Raises a once-per-frame tick for game-state updates during vertical blanking.
- Sits between the board pins and the game logic; the upstream end of the coordinate/colour interface.

Parameters:
- CLK_DIV, 2, system clocks per pixel (2 gives 25 MHz pixel rate from 50 MHz clk); legal range 1..16.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- x_crd  out  10  current horizontal pixel counter, 0..H_TOTAL-1.
- y_crd  out  10  current vertical line counter, 0..V_TOTAL-1.
- red_ch  in  1  renderer red bit for (x_crd, y_crd), combinational from the renderer.
- green_ch  in  1  renderer green bit.
- blue_ch  in  1  renderer blue bit.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- red  out  1  registered, blanked red to the pin.
- green  out  1  registered, blanked green to the pin.
- blue  out  1  registered, blanked blue to the pin.
- video_on  out  1  high while the pins carry an active pixel.
- frame_tick  out  1  one-clk pulse per frame.

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en is high for the one clk where div_cnt = CLK_DIV-1.
  - With CLK_DIV=1, pix_en is high every clk.
- Counters (stage 0), advancing only on pix_en:
  - h_cnt increments and wraps from H_TOTAL-1 to 0.
  - v_cnt increments on the same pix_en where h_cnt wraps.
  - v_cnt wraps from V_TOTAL-1 to 0.
  - x_crd = h_cnt and y_crd = v_cnt, both registered.
- Per-axis phase FSM (same for H and V): ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each transition happens on the pix_en (H) or line wrap (V) where the counter reaches a phase end.
  - H phase ends: 639, 655, 751, 799.
  - V phase ends: 479, 489, 491, 524.
  - FSM state is registered and decoded from the counter compare, never from the output pins.
- Output stage 1, updated on pix_en:
  - Captures the previous stage-0 phase and the colour inputs.
  - hsync = 0 iff the H phase was SYNC; vsync = 0 iff the V phase was SYNC.
  - video_on = (H ACTIVE && V ACTIVE).
  - red/green/blue = *_ch & video_on term.
  - Latency: the pins reflect coordinate (x, y) exactly one pixel period after x_crd/y_crd present it, so sync and colour stay mutually aligned.
- frame_tick:
  - Pulses high for exactly one clk on the pix_en where h_cnt = H_TOTAL-1 and v_cnt = V_ACTIVE-1 (end of the last visible line).
  - It is low at all other times.
- Reset, asynchronous:
  - div_cnt, h_cnt, v_cnt, x_crd, y_crd = 0.
  - Both FSMs in ACTIVE.
  - hsync = vsync = 1 (inactive).
  - red = green = blue = video_on = frame_tick = 0.
  - Reset asserted mid-frame forces these values immediately.
  - After release, the first pix_en occurs CLK_DIV clks later and counting restarts at (0,0).
- Between pix_en edges, all outputs hold their values.
- Colour inputs are sampled only on pix_en; glitches between enables are ignored.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480 timing constants and H_TOTAL/V_TOTAL.
  - The 2-bit phase encoding: ACTIVE = 0, FRONT = 1, SYNC = 2, BACK = 3.
- One natural sub-module, vga_axis_counter:
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Inputs: clk, rst, step.
  - Outputs: cnt, phase, wrap.
  - Instantiated twice: horizontal with step = pix_en; vertical with step = pix_en & h_wrap.

Test Plan:
- Reset: rst held 5 clks then released -> during rst hsync=vsync=1, rgb=0, x_crd=y_crd=0; first x_crd=1 occurs 2 clks after release (CLK_DIV=2).
- Line timing: run one line -> hsync low for exactly 96 pixels = 192 clks; falling edge 657 pixels after x_crd=0 (656 plus 1 pipeline stage); line period 1600 clks.
- Frame timing: run 2 frames -> vsync low for 2 lines = 3200 clks; frame period 840000 clks; frame_tick pulses once per frame, 1 clk wide, when x_crd=799, y_crd=479.
- Blanking: tie red_ch=green_ch=blue_ch=1 -> pins high only while video_on; count of high pixels per frame = 307200; pins 0 throughout x_crd 640..799 and y_crd 480..524.
- Alignment: red_ch = (x_crd==100) -> red high for exactly one pixel per visible line, asserted in the pixel period after x_crd=100.
- Mid-frame reset: assert rst at x_crd=300, y_crd=200 -> outputs return to reset values within the same clk; after release, counting restarts at (0,0) with a correct full frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for 640x480@60 Hz and the per-axis phase
//   encoding used by the sync generator and its axis counters.
//   Contents:
//     *_DEF        standard 640x480 porch/sync/active lengths
//     H_TOTAL      pixels per line (800)
//     V_TOTAL      lines per frame (525)
//     CRD_W        coordinate bus width
//     phase_t      ACTIVE=0, FRONT=1, SYNC=2, BACK=3
//     next_phase() successor in the ACTIVE->FRONT->SYNC->BACK ring
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FRONT_DEF  = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BACK_DEF   = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FRONT_DEF  = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BACK_DEF   = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int CRD_W = 10;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            PH_ACTIVE: n = PH_FRONT;
            PH_FRONT:  n = PH_SYNC;
            PH_SYNC:   n = PH_BACK;
            default:   n = PH_ACTIVE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   One timing axis (horizontal or vertical): a wrapping position counter
//   plus a registered phase FSM. The phase advances when the counter sits
//   on the last position of the current phase and a step arrives, so the
//   registered phase always describes the registered count.
//   Ports:
//     clk    in   system clock
//     rst    in   asynchronous active-high reset
//     step   in   advance one position this clk
//     cnt    out  current position, 0..TOTAL-1
//     phase  out  phase of the current position
//     wrap   out  high on the step that takes cnt from TOTAL-1 back to 0
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FRONT  = H_FRONT_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BACK   = H_BACK_DEF,
    parameter int CNT_W  = CRD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] END_BACK   = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] r_cnt;
    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [CNT_W-1:0] w_phase_end;
    logic             w_last;

    assign w_last = (r_cnt == END_BACK);
    assign wrap   = step & w_last;
    assign cnt    = r_cnt;
    assign phase  = r_phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (step) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PH_ACTIVE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_end = END_ACTIVE;
        w_phase_nxt = r_phase;
        case (r_phase)
            PH_ACTIVE: w_phase_end = END_ACTIVE;
            PH_FRONT:  w_phase_end = END_FRONT;
            PH_SYNC:   w_phase_end = END_SYNC;
            default:   w_phase_end = END_BACK;
        endcase
        if (step && (r_cnt == w_phase_end)) begin
            w_phase_nxt = next_phase(r_phase);
        end
    end

endmodule

// File: rtl/vga_sync.sv
// vga_sync
//   640x480@60 Hz VGA timing generator. Stage 0 holds the pixel/line
//   counters presented to the renderer as x_crd/y_crd; stage 1 registers
//   the renderer's colour bits together with the stage-0 phases, so the
//   sync and colour pins describe the same pixel one pixel period after
//   the coordinates were presented.
//   Ports:
//     clk          in   system clock
//     rst          in   asynchronous active-high reset
//     x_crd/y_crd  out  current pixel / line counter
//     *_ch         in   renderer colour bits for (x_crd, y_crd)
//     hsync/vsync  out  active-low sync pulses
//     red/green/blue out registered, blanked colour to the pins
//     video_on     out  pins carry an active pixel
//     frame_tick   out  one-clk pulse at the end of the last visible line
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FRONT  = H_FRONT_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BACK   = H_BACK_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FRONT  = V_FRONT_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BACK   = V_BACK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CRD_W-1:0] x_crd,
    output logic [CRD_W-1:0] y_crd,
    input  logic             red_ch,
    input  logic             green_ch,
    input  logic             blue_ch,
    output logic             hsync,
    output logic             vsync,
    output logic             red,
    output logic             green,
    output logic             blue,
    output logic             video_on,
    output logic             frame_tick
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    // A 1-bit divider that never leaves 0 keeps CLK_DIV=1 on the same path.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CRD_W-1:0] H_LAST     = CRD_W'(H_TOT - 1);
    localparam logic [CRD_W-1:0] V_LAST_VIS = CRD_W'(V_ACTIVE - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_pix_en;

    logic [CRD_W-1:0] w_h_cnt;
    logic [CRD_W-1:0] w_v_cnt;
    phase_t           w_h_phase;
    phase_t           w_v_phase;
    logic             w_h_wrap;
    logic             w_unused_v_wrap;
    logic             w_v_step;
    logic             w_active;

    logic r_hsync;
    logic r_vsync;
    logic r_video_on;
    logic r_red;
    logic r_green;
    logic r_blue;
    logic r_frame_tick;

    assign w_pix_en = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_pix_en) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .CNT_W  (CRD_W)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (w_pix_en),
        .cnt    (w_h_cnt),
        .phase  (w_h_phase),
        .wrap   (w_h_wrap)
    );

    assign w_v_step = w_pix_en & w_h_wrap;

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .CNT_W  (CRD_W)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (w_v_step),
        .cnt    (w_v_cnt),
        .phase  (w_v_phase),
        .wrap   (w_unused_v_wrap)
    );

    assign x_crd    = w_h_cnt;
    assign y_crd    = w_v_cnt;
    assign w_active = (w_h_phase == PH_ACTIVE) && (w_v_phase == PH_ACTIVE);

    // Stage 1: colour bits are combinational from the coordinates, so they
    // are captured on the same enable as the phase of those coordinates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
            r_red      <= 1'b0;
            r_green    <= 1'b0;
            r_blue     <= 1'b0;
        end else if (w_pix_en) begin
            r_hsync    <= (w_h_phase != PH_SYNC);
            r_vsync    <= (w_v_phase != PH_SYNC);
            r_video_on <= w_active;
            r_red      <= red_ch   & w_active;
            r_green    <= green_ch & w_active;
            r_blue     <= blue_ch  & w_active;
        end
    end

    // Updated every clk so the pulse is exactly one clk wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_pix_en && (w_h_cnt == H_LAST) && (w_v_cnt == V_LAST_VIS);
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign red        = r_red;
    assign green      = r_green;
    assign blue       = r_blue;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync.sv
module tb_vga_sync;

    localparam int CLK_DIV = 2;
    localparam int HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int VA = 10, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       r;
        logic       g;
        logic       b;
        logic       vid;
        logic       ft;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       red_ch = 1'b0, green_ch = 1'b0, blue_ch = 1'b0;
    logic [9:0] x_crd, y_crd;
    logic       hsync, vsync, red, green, blue, video_on, frame_tick;

    vga_sync #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x_crd      (x_crd),
        .y_crd      (y_crd),
        .red_ch     (red_ch),
        .green_ch   (green_ch),
        .blue_ch    (blue_ch),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .video_on   (video_on),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    obs_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         mode = 0;          // 0 random colour, 1 all ones, 2 red at x==5
    int         clk_cnt = 0;       // model: posedges since reset release
    logic [2:0] rgb_s = 3'b000;    // model: colour captured at last pixel edge
    int         tick_exp = 0;
    int         tick_dut = 0;
    int         red_clks_exp = 0;
    int         red_clks_dut = 0;

    // Pixel p = number of pixel periods elapsed; pins show pixel p-1.
    function automatic obs_t model(input int c, input logic [2:0] rgb);
        obs_t o;
        int   p, q, xq, yq;
        logic vid;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        p = c / CLK_DIV;
        o.x = 10'(p % HT);
        o.y = 10'((p / HT) % VT);
        if (p > 0) begin
            q   = p - 1;
            xq  = q % HT;
            yq  = (q / HT) % VT;
            vid = (xq < HA) && (yq < VA);
            o.hs  = !((xq >= HA + HF) && (xq < HA + HF + HS));
            o.vs  = !((yq >= VA + VF) && (yq < VA + VF + VS));
            o.vid = vid;
            o.r   = rgb[2] & vid;
            o.g   = rgb[1] & vid;
            o.b   = rgb[0] & vid;
            o.ft  = ((c % CLK_DIV) == 0) && (xq == HT - 1) && (yq == VA - 1);
        end
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t a;
        a = '{x: x_crd, y: y_crd, hs: hsync, vs: vsync, r: red, g: green,
              b: blue, vid: video_on, ft: frame_tick};
        return a;
    endfunction

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = sample();
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b rgb=%b%b%b vid=%b ft=%b expected x=%0d y=%0d hs=%b vs=%b rgb=%b%b%b vid=%b ft=%b",
                     name, $time, a.x, a.y, a.hs, a.vs, a.r, a.g, a.b, a.vid, a.ft,
                     e.x, e.y, e.hs, e.vs, e.r, e.g, e.b, e.vid, e.ft);
        end
    endtask

    // Stimulus + model: drive colour for the next edge and push what the
    // pins must show after it.
    initial begin
        int   p_cur;
        obs_t e;
        forever begin
            @(negedge clk);
            p_cur = clk_cnt / CLK_DIV;
            case (mode)
                0: {red_ch, green_ch, blue_ch} = 3'($urandom_range(0, 7));
                1: {red_ch, green_ch, blue_ch} = 3'b111;
                default: begin
                    red_ch   = ((p_cur % HT) == 5);
                    green_ch = 1'b0;
                    blue_ch  = 1'b0;
                end
            endcase
            if (rst) begin
                clk_cnt = 0;
                rgb_s   = 3'b000;
            end else begin
                clk_cnt++;
                if ((clk_cnt % CLK_DIV) == 0) rgb_s = {red_ch, green_ch, blue_ch};
            end
            e = model(clk_cnt, rgb_s);
            exp_q.push_back(e);
        end
    end

    // Monitor: every clk the pins present a new observation.
    initial begin
        obs_t e;
        @(negedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_underflow t=%0t got none expected one", $time);
            end else begin
                e = exp_q.pop_front();
                check("pins", e);
                tick_exp += int'(e.ft);
                tick_dut += int'(frame_tick);
                if (mode == 2) begin
                    red_clks_exp += int'(e.r);
                    red_clks_dut += int'(red);
                end
            end
        end
    end

    task automatic run_clks(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        obs_t rst_obs;
        int   p;
        rst_obs = '0;
        rst_obs.hs = 1'b1;
        rst_obs.vs = 1'b1;

        run_clks(5);
        rst = 1'b0;

        run_clks(2 * FRAME_CLKS);
        mode = 1;
        run_clks(FRAME_CLKS);
        mode = 2;
        run_clks(FRAME_CLKS);
        mode = 0;

        p = clk_cnt / CLK_DIV;
        for (int i = 0; i < FRAME_CLKS && !(((p % HT) == 7) && (((p / HT) % VT) == 5)); i++) begin
            run_clks(1);
            p = clk_cnt / CLK_DIV;
        end
        run_clks(1);
        rst = 1'b1;
        #1;
        check("midframe_reset_immediate", rst_obs);
        run_clks(3);
        rst = 1'b0;
        run_clks(FRAME_CLKS + FRAME_CLKS / 2);

        vectors++;
        if (tick_dut != tick_exp || tick_exp == 0) begin
            miscompares++;
            $display("FAIL frame_tick_count got %0d expected %0d", tick_dut, tick_exp);
        end
        vectors++;
        if (red_clks_dut != red_clks_exp || red_clks_exp != VA * CLK_DIV) begin
            miscompares++;
            $display("FAIL align_red_clks got %0d expected %0d", red_clks_dut, VA * CLK_DIV);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
